// File: rtl/regfile_write_queue_if.sv
// Writeback bus between the two producers, the register file write port and
// the forwarding lookup.
interface regfile_write_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          mem_valid;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          we;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          empty;

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, fwd_addr,
    input  mem_ready, alu_ready, we, A3, WD3, fwd_hit, fwd_data, empty
  );

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, fwd_addr,
    output mem_ready, alu_ready, we, A3, WD3, fwd_hit, fwd_data, empty
  );
endinterface

// File: rtl/regfile_write_queue.sv
// In-order writeback queue feeding the single register file write port,
// with a youngest-first forwarding lookup over pending writes.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_write_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LIM1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LIM2 = CW'(DEPTH - 2);

  logic [CW-1:0] count_r;
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [AW-1:0] rd_mem_r   [DEPTH];
  logic [DW-1:0] data_mem_r [DEPTH];
  logic          we_r;
  logic [AW-1:0] a3_r;
  logic [DW-1:0] wd3_r;

  logic          mem_ready_s;
  logic          alu_ready_s;
  logic          mem_push_s;
  logic          alu_push_s;
  logic          pop_s;
  logic [PW-1:0] alu_slot_s;
  logic [PW-1:0] idx_s;
  logic          fwd_hit_s;
  logic [DW-1:0] fwd_data_s;

  // Readiness looks only at the pre-edge count, so a reserved pair of slots
  // is needed whenever both producers may push together.
  assign mem_ready_s = (count_r <= LIM1);
  assign alu_ready_s = bus.mem_valid ? (count_r <= LIM2) : (count_r <= LIM1);
  assign mem_push_s  = bus.mem_valid & mem_ready_s & (bus.mem_rd != {AW{1'b0}});
  assign alu_push_s  = bus.alu_valid & alu_ready_s & (bus.alu_rd != {AW{1'b0}});
  assign pop_s       = (count_r != {CW{1'b0}});
  assign alu_slot_s  = tail_r + PW'(mem_push_s);

  // Queue storage, pointers, count and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      we_r    <= 1'b0;
      a3_r    <= {AW{1'b0}};
      wd3_r   <= {DW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_r[i]   <= {AW{1'b0}};
        data_mem_r[i] <= {DW{1'b0}};
      end
    end else begin
      if (mem_push_s) begin
        rd_mem_r[tail_r]   <= bus.mem_rd;
        data_mem_r[tail_r] <= bus.mem_data;
      end
      if (alu_push_s) begin
        rd_mem_r[alu_slot_s]   <= bus.alu_rd;
        data_mem_r[alu_slot_s] <= bus.alu_data;
      end
      if (pop_s) begin
        we_r   <= 1'b1;
        a3_r   <= rd_mem_r[head_r];
        wd3_r  <= data_mem_r[head_r];
        head_r <= head_r + PW'(1'b1);
      end else begin
        we_r   <= 1'b0;
      end
      tail_r  <= tail_r + PW'(mem_push_s) + PW'(alu_push_s);
      count_r <= count_r + CW'(mem_push_s) + CW'(alu_push_s) - CW'(pop_s);
    end
  end

  // Forwarding: walk oldest to youngest so the last match wins; the output
  // register is older than every queued entry.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DW{1'b0}};
    idx_s      = head_r;
    if (bus.fwd_addr != {AW{1'b0}}) begin
      if (we_r && (a3_r == bus.fwd_addr)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = wd3_r;
      end else begin
        fwd_hit_s  = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx_s = head_r + PW'(i);
        if ((CW'(i) < count_r) && (rd_mem_r[idx_s] == bus.fwd_addr)) begin
          fwd_hit_s  = 1'b1;
          fwd_data_s = data_mem_r[idx_s];
        end else begin
          fwd_hit_s  = fwd_hit_s;
        end
      end
    end else begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = {DW{1'b0}};
    end
  end

  assign bus.mem_ready = mem_ready_s;
  assign bus.alu_ready = alu_ready_s;
  assign bus.we        = we_r;
  assign bus.A3        = a3_r;
  assign bus.WD3       = wd3_r;
  assign bus.fwd_hit   = fwd_hit_s;
  assign bus.fwd_data  = fwd_data_s;
  assign bus.empty     = (count_r == {CW{1'b0}}) && !we_r;
endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed, table-driven bench for regfile_write_queue (DEPTH=4) plus a
// hand-written asynchronous-reset sequence.
module tb_regfile_write_queue;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  regfile_write_queue_if #(.AW(5), .DW(32)) bus ();

  regfile_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic [4:0]  fa;
    logic        mr;
    logic        ar;
    logic        hit;
    logic [31:0] fd;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        emp;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] fa);
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = md;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.fwd_addr  = fa;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    //          mv    mrd    md         av    ard    ad         fa     mr    ar    hit   fd          we    a3     wd         emp
    vecs[0]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd5,  32'hAA,    5'd5,  1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 5'd0,  32'h0,    1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd5,  1'b1, 1'b1, 1'b1, 32'hAA,     1'b1, 5'd5,  32'hAA,   1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd5,  1'b1, 1'b1, 1'b1, 32'hAA,     1'b0, 5'd5,  32'hAA,   1'b1};
    vecs[3]  = '{1'b1, 5'd3,  32'h11,   1'b1, 5'd4,  32'h22,    5'd4,  1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 5'd5,  32'hAA,   1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd4,  1'b1, 1'b1, 1'b1, 32'h22,     1'b1, 5'd3,  32'h11,   1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd3,  1'b1, 1'b1, 1'b1, 32'h11,     1'b1, 5'd4,  32'h22,   1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'hDEAD,  5'd0,  1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 5'd4,  32'h22,   1'b1};
    vecs[7]  = '{1'b1, 5'd0,  32'hDEAD, 1'b0, 5'd0,  32'h0,     5'd4,  1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 5'd4,  32'h22,   1'b1};
    vecs[8]  = '{1'b1, 5'd7,  32'h1,    1'b1, 5'd7,  32'h2,     5'd7,  1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 5'd4,  32'h22,   1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd7,  1'b1, 1'b1, 1'b1, 32'h2,      1'b1, 5'd7,  32'h1,    1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd7,  1'b1, 1'b1, 1'b1, 32'h2,      1'b1, 5'd7,  32'h2,    1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd7,  1'b1, 1'b1, 1'b1, 32'h2,      1'b0, 5'd7,  32'h2,    1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd7,  1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 5'd7,  32'h2,    1'b1};
    vecs[13] = '{1'b1, 5'd10, 32'hA0,   1'b1, 5'd11, 32'hB0,    5'd10, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 5'd7,  32'h2,    1'b0};
    vecs[14] = '{1'b1, 5'd12, 32'hA1,   1'b1, 5'd13, 32'hB1,    5'd11, 1'b1, 1'b1, 1'b1, 32'hB0,     1'b1, 5'd10, 32'hA0,   1'b0};
    vecs[15] = '{1'b1, 5'd14, 32'hA2,   1'b1, 5'd15, 32'hB2,    5'd12, 1'b1, 1'b0, 1'b1, 32'hA1,     1'b1, 5'd11, 32'hB0,   1'b0};
    vecs[16] = '{1'b1, 5'd16, 32'hA3,   1'b1, 5'd15, 32'hB2,    5'd15, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 5'd12, 32'hA1,   1'b0};
    vecs[17] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd15, 32'hB2,    5'd14, 1'b1, 1'b1, 1'b1, 32'hA2,     1'b1, 5'd13, 32'hB1,   1'b0};
    vecs[18] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd16, 1'b1, 1'b1, 1'b1, 32'hA3,     1'b1, 5'd14, 32'hA2,   1'b0};
    vecs[19] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd15, 1'b1, 1'b1, 1'b1, 32'hB2,     1'b1, 5'd16, 32'hA3,   1'b0};
    vecs[20] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd0,  1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 5'd15, 32'hB2,   1'b0};
    vecs[21] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,     5'd15, 1'b1, 1'b1, 1'b1, 32'hB2,     1'b0, 5'd15, 32'hB2,   1'b1};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
    #12;
    check("reset_we",    {31'd0, bus.we},    {31'd0, 1'b0});
    check("reset_A3",    {27'd0, bus.A3},    32'h0);
    check("reset_WD3",   bus.WD3,            32'h0);
    check("reset_empty", {31'd0, bus.empty}, {31'd0, 1'b1});
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) begin
      drive(vecs[v].mv, vecs[v].mrd, vecs[v].md, vecs[v].av, vecs[v].ard, vecs[v].ad, vecs[v].fa);
      #1;
      check($sformatf("v%0d_mem_ready", v), {31'd0, bus.mem_ready}, {31'd0, vecs[v].mr});
      check($sformatf("v%0d_alu_ready", v), {31'd0, bus.alu_ready}, {31'd0, vecs[v].ar});
      check($sformatf("v%0d_fwd_hit", v),   {31'd0, bus.fwd_hit},   {31'd0, vecs[v].hit});
      check($sformatf("v%0d_fwd_data", v),  bus.fwd_data,           vecs[v].fd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we", v),    {31'd0, bus.we},    {31'd0, vecs[v].we});
      check($sformatf("v%0d_A3", v),    {27'd0, bus.A3},    {27'd0, vecs[v].a3});
      check($sformatf("v%0d_WD3", v),   bus.WD3,            vecs[v].wd);
      check($sformatf("v%0d_empty", v), {31'd0, bus.empty}, {31'd0, vecs[v].emp});
    end

    // Three entries queued with a write in flight, then reset between edges.
    drive(1'b1, 5'd20, 32'hC0, 1'b1, 5'd21, 32'hC1, 5'd0);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd22, 32'hC2, 1'b1, 5'd23, 32'hC3, 5'd0);
    @(posedge clk);
    #1;
    check("pre_rst_we", {31'd0, bus.we}, {31'd0, 1'b1});
    check("pre_rst_A3", {27'd0, bus.A3}, 32'd20);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd23);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_we",    {31'd0, bus.we},      {31'd0, 1'b0});
    check("async_rst_A3",    {27'd0, bus.A3},      32'h0);
    check("async_rst_WD3",   bus.WD3,              32'h0);
    check("async_rst_empty", {31'd0, bus.empty},   {31'd0, 1'b1});
    check("async_rst_hit",   {31'd0, bus.fwd_hit}, {31'd0, 1'b0});
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d_we", c),    {31'd0, bus.we},        {31'd0, 1'b0});
      check($sformatf("post_rst%0d_empty", c), {31'd0, bus.empty},     {31'd0, 1'b1});
      check($sformatf("post_rst%0d_ready", c), {31'd0, bus.mem_ready}, {31'd0, 1'b1});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
